sync_frame_fifo: RTL and testbench
==================================

Name: sync_frame_fifo

Overview:
Single-clock, parametrised store-and-forward frame FIFO for the Ethernet datapath. Data width, depth and thresholds are generic. A frame becomes visible to the reader only after its last word (EOD) is written. Partial frames can be aborted and rolled back, and overflowing frames are dropped whole and counted, so the reader only ever sees complete frames.

Parameters:
DW, 8, data word width in bits
AW, 13, address width; DEPTH = 2**AW words
AFULL_CNT, 6678, afull asserts when used words (committed plus pending) >= AFULL_CNT
AEMPTY_CNT, 1514, aempty asserts when committed unread words <= AEMPTY_CNT
CW, 8, width of frame_cnt and drop_cnt

Ports:
clk  in  1  single clock; all logic on its rising edge
arst_n  in  1  asynchronous active-low reset
wr_data  in  DW  write word
wr_en  in  1  write strobe
wr_eod  in  1  qualifies wr_en; this word ends the frame
wr_abort  in  1  discard the current partial frame (wr_en not required)
full  out  1  used words == DEPTH
afull  out  1  almost-full threshold flag
rd_data  out  DW  head word (first-word fall-through)
rd_eod  out  1  head word ends its frame
rd_valid  out  1  rd_data/rd_eod hold a committed word
rd_en  in  1  pop head; ignored when rd_valid=0
aempty  out  1  almost-empty threshold flag (committed data only)
frame_cnt  out  CW  complete frames stored, not yet fully popped
frame_exist  out  1  frame_cnt != 0
drop_cnt  out  CW  saturating count of aborted or overflow-dropped frames
drop_pulse  out  1  one-cycle pulse per dropped frame

Behaviour:
- Reset (async assert, sync-released internally through a 2FF): all pointers and counters = 0; full=afull=rd_valid=frame_exist=drop_pulse=0; aempty=1; rd_data/rd_eod = 0.
- Memory: DEPTH x (DW+1), where the extra bit stores EOD. Synchronous read, one cycle.
- Pointers are AW+1 bits with natural wrap:
  - wptr = speculative write pointer
  - cptr = commit pointer
  - rptr = RAM read pointer
  - used = wptr-rptr; committed = cptr-rptr.
- Write accepted when wr_en & ~full & ~err. Word goes to RAM[wptr], then wptr+1.
- Commit: an accepted write with wr_eod sets cptr <= wptr+1 on the same edge and increments frame_cnt.
- Overflow: wr_en while full sets err. The word is discarded, and further words of that frame are discarded. On that frame's wr_eod: wptr <= cptr, err cleared, drop_cnt+1, drop_pulse. No commit occurs.
- Abort: wr_abort sets wptr <= cptr, clears err, drop_cnt+1, drop_pulse. If a write is also present that cycle, it is discarded. Abort wins over wr_eod in the same cycle. If wptr==cptr and err=0, abort is a no-op and is not counted.
- drop_cnt saturates at 2**CW-1.
- Read path: a prefetch stage fills the output register whenever rptr != cptr and the register is empty or being popped. This gives sustained 1 word/cycle.
- Latency: commit edge N -> rd_valid=1 at edge N+2 (RAM read, then output register).
- Pop: rd_en & rd_valid advances the head. A popped word with rd_eod decrements frame_cnt.
- Same-cycle commit and EOD pop: frame_cnt unchanged.
- frame_cnt cannot exceed DEPTH frames. CW must be wide enough for the application; no saturation check.
- Flags are registered from next-state pointers, so each is valid in the cycle after the causing event:
  - full = (used_next == DEPTH)
  - afull = (used_next >= AFULL_CNT)
  - aempty = (committed_next + rd_valid_next <= AEMPTY_CNT)
- The output-register word counts as committed, unread data for aempty.
- Pending (uncommitted) words never make rd_valid=1, but they consume space and count toward full and afull.
- Space is freed only by pops (rptr) or by rollback (wptr <= cptr).

Test Plan:
- 64-byte frame (wr_eod on word 63) -> rd_valid rises 2 cycles after the EOD write; 64 words read back identical with rd_eod only on word 63; frame_cnt 1->0.
- 40 words then wr_abort, then a 10-word frame -> reader sees only the 10 words; drop_cnt=1; a single drop_pulse.
- AW=4: 16 words written without EOD -> full=1; 17th word plus EOD -> frame dropped, wptr back to 0, full=0, drop_cnt=1, rd_valid stays 0.
- Back-to-back 3-word frames, write and read every cycle for 2**AW+5 words -> pointer wrap; data in order; frame_cnt never exceeds 2; no drops.
- Commit and final-word pop in the same cycle -> frame_cnt holds at 1; wr_eod and wr_abort in the same cycle -> abort, no commit.
- arst_n low mid-frame with 2 frames stored -> all outputs return to reset values immediately; the next frame reads back cleanly.

Source files
------------

// File: rtl/sync_frame_fifo_if.sv
// Write/read bundle of the store-and-forward frame FIFO.
// master = producer/consumer side, slave = FIFO side.
interface sync_frame_fifo_if #(
  parameter int DW = 8,
  parameter int CW = 8
);
  logic [DW-1:0] wr_data;
  logic          wr_en;
  logic          wr_eod;
  logic          wr_abort;
  logic          full;
  logic          afull;
  logic [DW-1:0] rd_data;
  logic          rd_eod;
  logic          rd_valid;
  logic          rd_en;
  logic          aempty;
  logic [CW-1:0] frame_cnt;
  logic          frame_exist;
  logic [CW-1:0] drop_cnt;
  logic          drop_pulse;

  modport master (
    output wr_data, wr_en, wr_eod, wr_abort, rd_en,
    input  full, afull, rd_data, rd_eod, rd_valid,
    input  aempty, frame_cnt, frame_exist,
    input  drop_cnt, drop_pulse
  );

  modport slave (
    input  wr_data, wr_en, wr_eod, wr_abort, rd_en,
    output full, afull, rd_data, rd_eod, rd_valid,
    output aempty, frame_cnt, frame_exist,
    output drop_cnt, drop_pulse
  );
endinterface

// File: rtl/sync_frame_fifo.sv
// Single-clock store-and-forward frame FIFO: frames become
// readable only once complete; partial/overflowed frames roll back.
module sync_frame_fifo #(
  parameter int DW         = 8,
  parameter int AW         = 13,
  parameter int AFULL_CNT  = 6678,
  parameter int AEMPTY_CNT = 1514,
  parameter int CW         = 8
) (
  input logic              clk,
  input logic              arst_n,
  sync_frame_fifo_if.slave bus
);
  localparam int DEPTH = 2**AW;
  localparam int PW    = AW + 1;
  localparam int LW    = AW + 2;

  typedef logic [PW-1:0] ptr_t;

  localparam ptr_t          DEPTH_P = PW'(DEPTH);
  localparam ptr_t          AF_P    = PW'(AFULL_CNT);
  localparam logic [LW-1:0] AE_L    = LW'(AEMPTY_CNT);

  logic [1:0] rst_sync;
  logic       rst_n;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) rst_sync <= '0;
    else         rst_sync <= {rst_sync[0], 1'b1};
  end

  assign rst_n = rst_sync[1];

  logic [DW:0]   mem [DEPTH];
  logic [DW:0]   ram_q;
  ptr_t          wptr, cptr, rptr;
  ptr_t          wptr_n, cptr_n, rptr_n;
  ptr_t          used_p, comm_p;
  logic [LW-1:0] avail_n;
  logic          err, err_n;
  logic          ram_vld, ram_vld_n;
  logic          rd_valid, rd_valid_n;
  logic [DW-1:0] rd_data;
  logic          rd_eod;
  logic          full, afull, aempty;
  logic [CW-1:0] frame_cnt, frame_cnt_n;
  logic [CW-1:0] drop_cnt, drop_cnt_n;
  logic          drop_pulse;
  logic          wr_acc, commit, pop;
  logic          abort_do, ovf_drop, drop;
  logic          issue, out_load;

  assign pop      = bus.rd_en & rd_valid;
  assign out_load = ram_vld & (~rd_valid | pop);
  // stage 1 (RAM output) refills when empty or draining
  assign issue    = (rptr != cptr) & (~ram_vld | out_load);

  assign wr_acc   = bus.wr_en & ~full & ~err & ~bus.wr_abort;
  assign commit   = wr_acc & bus.wr_eod;
  assign abort_do = bus.wr_abort & ((wptr != cptr) | err);
  assign ovf_drop = ~bus.wr_abort & bus.wr_en & bus.wr_eod
                  & (full | err);
  assign drop     = abort_do | ovf_drop;

  always_comb begin
    wptr_n      = wptr;
    cptr_n      = cptr;
    err_n       = err;
    drop_cnt_n  = drop_cnt;
    if (bus.wr_abort) begin
      err_n = 1'b0;
      if (abort_do) wptr_n = cptr;
    end else if (ovf_drop) begin
      wptr_n = cptr;
      err_n  = 1'b0;
    end else if (wr_acc) begin
      wptr_n = wptr + PW'(1);
      if (bus.wr_eod) cptr_n = wptr + PW'(1);
    end else if (bus.wr_en) begin
      err_n = 1'b1;
    end
    if (drop && (drop_cnt != '1))
      drop_cnt_n = drop_cnt + CW'(1);
    frame_cnt_n = frame_cnt + CW'(commit)
                - CW'(pop & rd_eod);
    rptr_n      = rptr + PW'(issue);
    ram_vld_n   = issue | (ram_vld & ~out_load);
    rd_valid_n  = out_load | (rd_valid & ~pop);
    used_p      = wptr_n - rptr_n;
    comm_p      = cptr_n - rptr_n;
    avail_n     = {1'b0, comm_p} + LW'(ram_vld_n)
                + LW'(rd_valid_n);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr       <= '0;
      cptr       <= '0;
      rptr       <= '0;
      err        <= 1'b0;
      ram_vld    <= 1'b0;
      rd_valid   <= 1'b0;
      rd_data    <= '0;
      rd_eod     <= 1'b0;
      frame_cnt  <= '0;
      drop_cnt   <= '0;
      drop_pulse <= 1'b0;
      full       <= 1'b0;
      afull      <= 1'b0;
      aempty     <= 1'b1;
    end else begin
      wptr       <= wptr_n;
      cptr       <= cptr_n;
      rptr       <= rptr_n;
      err        <= err_n;
      ram_vld    <= ram_vld_n;
      rd_valid   <= rd_valid_n;
      frame_cnt  <= frame_cnt_n;
      drop_cnt   <= drop_cnt_n;
      drop_pulse <= drop;
      full       <= (used_p == DEPTH_P);
      afull      <= (used_p >= AF_P);
      aempty     <= (avail_n <= AE_L);
      if (out_load) {rd_eod, rd_data} <= ram_q;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc)
      mem[wptr[AW-1:0]] <= {bus.wr_eod, bus.wr_data};
  end

  always_ff @(posedge clk) begin
    if (issue) ram_q <= mem[rptr[AW-1:0]];
  end

  assign bus.full        = full;
  assign bus.afull       = afull;
  assign bus.rd_data     = rd_data;
  assign bus.rd_eod      = rd_eod;
  assign bus.rd_valid    = rd_valid;
  assign bus.aempty      = aempty;
  assign bus.frame_cnt   = frame_cnt;
  assign bus.frame_exist = (frame_cnt != '0);
  assign bus.drop_cnt    = drop_cnt;
  assign bus.drop_pulse  = drop_pulse;
endmodule

// File: tb/tb_sync_frame_fifo.sv
// Bench for sync_frame_fifo: two instances (deep and AW=4),
// queue-based frame model, randomized and directed scenarios.
module tb_sync_frame_fifo;
  localparam int DW   = 8;
  localparam int CW   = 8;
  localparam int BDEP = 128;
  localparam int SDEP = 16;

  logic clk = 1'b0;
  logic arst_n = 1'b0;
  always #5 clk = ~clk;

  sync_frame_fifo_if #(.DW(DW), .CW(CW)) bi ();
  sync_frame_fifo_if #(.DW(DW), .CW(CW)) si ();

  sync_frame_fifo #(
    .DW(DW), .AW(7), .AFULL_CNT(100),
    .AEMPTY_CNT(20), .CW(CW)
  ) u_big (.clk(clk), .arst_n(arst_n), .bus(bi));

  sync_frame_fifo #(
    .DW(DW), .AW(4), .AFULL_CNT(12),
    .AEMPTY_CNT(3), .CW(CW)
  ) u_small (.clk(clk), .arst_n(arst_n), .bus(si));

  int checks = 0;
  int errors = 0;
  int pulses = 0;
  bit sel = 1'b0;

  logic [DW:0] expq[$];
  logic [DW:0] pend[$];
  bit          err_m;
  int          drops[2];

  logic          o_valid, o_eod, o_full, o_afull, o_aempty;
  logic          o_fe, o_dp;
  logic [DW-1:0] o_data;
  logic [CW-1:0] o_fc, o_dc;

  function automatic int eod_count();
    int n = 0;
    foreach (expq[i]) if (expq[i][DW]) n++;
    return n;
  endfunction

  task automatic model_clear();
    expq.delete();
    pend.delete();
    err_m = 1'b0;
  endtask

  task automatic sample();
    if (sel) begin
      o_valid = si.rd_valid; o_eod = si.rd_eod;
      o_data = si.rd_data; o_full = si.full;
      o_afull = si.afull; o_aempty = si.aempty;
      o_fc = si.frame_cnt; o_dc = si.drop_cnt;
      o_fe = si.frame_exist; o_dp = si.drop_pulse;
    end else begin
      o_valid = bi.rd_valid; o_eod = bi.rd_eod;
      o_data = bi.rd_data; o_full = bi.full;
      o_afull = bi.afull; o_aempty = bi.aempty;
      o_fc = bi.frame_cnt; o_dc = bi.drop_cnt;
      o_fe = bi.frame_exist; o_dp = bi.drop_pulse;
    end
  endtask

  task automatic drive(input bit en, input bit eod,
                       input bit ab, input logic [DW-1:0] d,
                       input bit rd);
    bi.wr_en = !sel && en;  si.wr_en = sel && en;
    bi.wr_eod = eod;        si.wr_eod = eod;
    bi.wr_abort = !sel && ab; si.wr_abort = sel && ab;
    bi.wr_data = d;         si.wr_data = d;
    bi.rd_en = !sel && rd;  si.rd_en = sel && rd;
  endtask

  // one clock: check any pop against the model, then apply rules
  task automatic step(input bit en, input bit eod,
                      input bit ab, input logic [DW-1:0] d,
                      input bit rd);
    bit pop, full_m, dropped;
    int dep;
    dep = sel ? SDEP : BDEP;
    sample();
    full_m = (pend.size() + expq.size()) >= dep;
    pop = rd && (o_valid === 1'b1);
    checks++;
    if (o_valid === 1'b1 && expq.size() == 0) begin
      errors++;
      $display("FAIL phantom: rd_valid=%b with no committed word",
               o_valid);
    end
    if (pop && expq.size() > 0) begin
      checks++;
      if ({o_eod, o_data} !== expq[0]) begin
        errors++;
        $display("FAIL pop_data: got %h required %h",
                 {o_eod, o_data}, expq[0]);
      end
      void'(expq.pop_front());
    end
    drive(en, eod, ab, d, rd);
    @(posedge clk); #1;
    dropped = 1'b0;
    if (ab) begin
      if (pend.size() > 0 || err_m) dropped = 1'b1;
      pend.delete();
      err_m = 1'b0;
    end else if (en) begin
      if (err_m || full_m) begin
        err_m = 1'b1;
        if (eod) begin
          dropped = 1'b1;
          pend.delete();
          err_m = 1'b0;
        end
      end else begin
        pend.push_back({eod, d});
        if (eod) begin
          foreach (pend[i]) expq.push_back(pend[i]);
          pend.delete();
        end
      end
    end
    if (dropped && drops[sel] < 255) drops[sel]++;
    sample();
    if (o_dp === 1'b1) pulses++;
    checks += 4;
    if (o_fc !== CW'(eod_count())) begin
      errors++;
      $display("FAIL frame_cnt: got %0d required %0d",
               o_fc, eod_count());
    end
    if (o_fe !== (eod_count() != 0)) begin
      errors++;
      $display("FAIL frame_exist: got %b required %b",
               o_fe, eod_count() != 0);
    end
    if (o_dc !== CW'(drops[sel])) begin
      errors++;
      $display("FAIL drop_cnt: got %0d required %0d",
               o_dc, drops[sel]);
    end
    if (o_dp !== dropped) begin
      errors++;
      $display("FAIL drop_pulse: got %b required %b",
               o_dp, dropped);
    end
  endtask

  task automatic idle(input bit rd);
    step(1'b0, 1'b0, 1'b0, '0, rd);
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && expq.size() > 0; i++)
      idle(1'b1);
    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d words left, required 0",
               expq.size());
    end
    idle(1'b1);
    idle(1'b1);
    sample();
    checks++;
    if (o_valid !== 1'b0) begin
      errors++;
      $display("FAIL drained_valid: got %b required 0", o_valid);
    end
  endtask

  task automatic test_reset();
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      sample();
      checks += 3;
      if ({o_full, o_afull, o_valid, o_fe, o_dp, o_aempty,
           o_eod} !== 7'b0000010) begin
        errors++;
        $display("FAIL reset_flags[%0d]: got %b required 0000010",
                 s, {o_full, o_afull, o_valid, o_fe, o_dp,
                     o_aempty, o_eod});
      end
      if (o_data !== '0) begin
        errors++;
        $display("FAIL reset_data[%0d]: got %h required 00",
                 s, o_data);
      end
      if ({o_fc, o_dc} !== '0) begin
        errors++;
        $display("FAIL reset_cnt[%0d]: got %h required 0",
                 s, {o_fc, o_dc});
      end
    end
  endtask

  task automatic test_frame64();
    sel = 1'b0;
    model_clear();
    for (int i = 0; i < 64; i++)
      step(1'b1, i == 63, 1'b0, 8'($urandom), 1'b0);
    for (int k = 0; k < 3; k++) begin
      sample();
      checks++;
      if (o_valid !== (k == 2)) begin
        errors++;
        $display("FAIL latency[+%0d]: rd_valid %b required %b",
                 k, o_valid, k == 2);
      end
      if (k < 2) idle(1'b0);
    end
    idle(1'b0);
    idle(1'b0);
    sample();
    checks++;
    if ({o_aempty, o_afull, o_full} !== 3'b000) begin
      errors++;
      $display("FAIL f64_flags: got %b required 000",
               {o_aempty, o_afull, o_full});
    end
    drain(200);
  endtask

  task automatic test_abort();
    int p0;
    sel = 1'b0;
    model_clear();
    p0 = pulses;
    for (int i = 0; i < 40; i++)
      step(1'b1, 1'b0, 1'b0, 8'($urandom), 1'b0);
    step(1'b0, 1'b0, 1'b1, '0, 1'b0);
    for (int i = 0; i < 10; i++)
      step(1'b1, i == 9, 1'b0, 8'($urandom), 1'b0);
    drain(100);
    sample();
    checks += 2;
    if (pulses - p0 != 1) begin
      errors++;
      $display("FAIL abort_pulses: got %0d required 1",
               pulses - p0);
    end
    if (o_dc !== 8'd1) begin
      errors++;
      $display("FAIL abort_drops: got %0d required 1", o_dc);
    end
  endtask

  task automatic test_overflow();
    sel = 1'b1;
    model_clear();
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 1'b0, 1'b0, 8'($urandom), 1'b0);
      if (i == 10 || i == 11) begin
        checks++;
        if (o_afull !== (i == 11)) begin
          errors++;
          $display("FAIL afull_edge[%0d]: got %b required %b",
                   i + 1, o_afull, i == 11);
        end
      end
    end
    checks++;
    if ({o_full, o_valid} !== 2'b10) begin
      errors++;
      $display("FAIL ovf_full: full,valid %b required 10",
               {o_full, o_valid});
    end
    step(1'b1, 1'b1, 1'b0, 8'($urandom), 1'b0);
    checks += 2;
    if (o_full !== 1'b0) begin
      errors++;
      $display("FAIL ovf_release: full %b required 0", o_full);
    end
    if (o_dc !== 8'd1) begin
      errors++;
      $display("FAIL ovf_drops: got %0d required 1", o_dc);
    end
    for (int i = 0; i < 4; i++) idle(1'b0);
    for (int i = 0; i < 4; i++)
      step(1'b1, i == 3, 1'b0, 8'($urandom), 1'b0);
    for (int i = 0; i < 3; i++) idle(1'b0);
    sample();
    checks++;
    if (o_aempty !== 1'b0) begin
      errors++;
      $display("FAIL aempty_4w: got %b required 0", o_aempty);
    end
    drain(50);
    sample();
    checks++;
    if (o_aempty !== 1'b1) begin
      errors++;
      $display("FAIL aempty_0w: got %b required 1", o_aempty);
    end
  endtask

  task automatic test_back_to_back();
    sel = 1'b1;
    model_clear();
    for (int i = 0; i < SDEP + 5; i++) begin
      step(1'b1, (i % 3) == 2, 1'b0, 8'($urandom), 1'b1);
      checks++;
      if (o_fc > 8'd2) begin
        errors++;
        $display("FAIL b2b_frames: got %0d required <=2", o_fc);
      end
    end
    drain(30);
  endtask

  task automatic test_commit_pop();
    sel = 1'b0;
    model_clear();
    step(1'b1, 1'b0, 1'b0, 8'($urandom), 1'b0);
    step(1'b1, 1'b1, 1'b0, 8'($urandom), 1'b0);
    for (int i = 0; i < 10 && o_valid !== 1'b1; i++)
      idle(1'b0);
    checks++;
    if (o_valid !== 1'b1) begin
      errors++;
      $display("FAIL cp_wait: rd_valid %b required 1", o_valid);
    end
    step(1'b1, 1'b0, 1'b0, 8'($urandom), 1'b1);
    checks++;
    if ({o_valid, o_eod} !== 2'b11) begin
      errors++;
      $display("FAIL cp_head: valid,eod %b required 11",
               {o_valid, o_eod});
    end
    step(1'b1, 1'b1, 1'b0, 8'($urandom), 1'b1);
    checks++;
    if (o_fc !== 8'd1) begin
      errors++;
      $display("FAIL cp_hold: frame_cnt %0d required 1", o_fc);
    end
    step(1'b1, 1'b0, 1'b0, 8'($urandom), 1'b0);
    step(1'b1, 1'b1, 1'b1, 8'($urandom), 1'b0);
    checks++;
    if ({o_dp, o_fc} !== {1'b1, 8'd1}) begin
      errors++;
      $display("FAIL eod_abort: pulse,fc %h required 101",
               {o_dp, o_fc});
    end
    drain(50);
  endtask

  task automatic test_random();
    bit en, eod, ab, rd;
    sel = 1'b0;
    model_clear();
    for (int i = 0; i < 400; i++) begin
      en  = ($urandom % 10 < 7) &&
            (pend.size() + expq.size() < 100);
      eod = ($urandom % 8) == 0;
      ab  = ($urandom % 40) == 0;
      rd  = ($urandom % 10) < 6;
      step(en, eod, ab, 8'($urandom), rd);
    end
    if (pend.size() > 0 || err_m)
      step(1'b1, 1'b1, 1'b0, 8'($urandom), 1'b1);
    drain(400);
    sample();
    checks++;
    if ({o_aempty, o_afull, o_full} !== 3'b100) begin
      errors++;
      $display("FAIL rnd_flags: got %b required 100",
               {o_aempty, o_afull, o_full});
    end
  endtask

  task automatic test_reset_mid();
    sel = 1'b0;
    model_clear();
    for (int f = 0; f < 2; f++)
      for (int i = 0; i < 4; i++)
        step(1'b1, i == 3, 1'b0, 8'($urandom), 1'b0);
    for (int i = 0; i < 5; i++)
      step(1'b1, 1'b0, 1'b0, 8'($urandom), 1'b0);
    #3;
    arst_n = 1'b0;
    #1;
    sample();
    checks += 2;
    if ({o_valid, o_fe, o_aempty, o_full, o_dp}
        !== 5'b00100) begin
      errors++;
      $display("FAIL arst_flags: got %b required 00100",
               {o_valid, o_fe, o_aempty, o_full, o_dp});
    end
    if ({o_fc, o_dc, o_data} !== '0) begin
      errors++;
      $display("FAIL arst_cnt: got %h required 0",
               {o_fc, o_dc, o_data});
    end
    drive(1'b0, 1'b0, 1'b0, '0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    arst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    drops[0] = 0;
    drops[1] = 0;
    model_clear();
    for (int i = 0; i < 5; i++)
      step(1'b1, i == 4, 1'b0, 8'($urandom), 1'b0);
    drain(50);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not end in time");
    $fatal(1);
  end

  initial begin
    drops[0] = 0;
    drops[1] = 0;
    model_clear();
    drive(1'b0, 1'b0, 1'b0, '0, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    arst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    test_reset();
    test_frame64();
    test_abort();
    test_overflow();
    test_back_to_back();
    test_commit_pop();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
